// File: rtl/gs_writeback_unit.sv
// gs_writeback_unit: register-file writeback for the EX and LSU result paths,
// with a small load-response FIFO, load data formatting and a busy scoreboard.
module gs_writeback_unit #(
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  // EX result handshake
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd_addr,
  input  logic [31:0] ex_rd_data,
  // LSU load response handshake
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd_addr,
  input  logic [31:0] lsu_rdata,
  input  logic [2:0]  lsu_funct3,
  input  logic [1:0]  lsu_byte_off,
  // decode issue marks rd busy
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  // scoreboard query
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  input  logic        flush,
  // register-file write ports
  output logic        wb_ex_wen,
  output logic [4:0]  wb_ex_addr,
  output logic [31:0] wb_ex_data,
  output logic        wb_lsu_wen,
  output logic [4:0]  wb_lsu_addr,
  output logic [31:0] wb_lsu_data
);

  localparam int AW = (LSU_FIFO_DEPTH > 2) ? $clog2(LSU_FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(LSU_FIFO_DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } lsu_ent_t;

  // Load data is formatted on the way in so the FIFO only stores the final word.
  function automatic logic [31:0] lsu_fmt(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  lsu_fmt = {{24{b[7]}}, b};
      3'b001:  lsu_fmt = {{16{h[15]}}, h};
      3'b100:  lsu_fmt = {24'b0, b};
      3'b101:  lsu_fmt = {16'b0, h};
      default: lsu_fmt = w;
    endcase
  endfunction

  lsu_ent_t      fifo_mem [LSU_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, push, pop, ex_acc;
  lsu_ent_t      head;
  logic [31:0]   busy, busy_nxt;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign head  = fifo_mem[rd_ptr];

  // The FIFO drains one entry every cycle it holds anything.
  assign pop       = !empty && !flush;
  assign lsu_ready = !rst && !full && !flush;
  assign push      = lsu_valid && lsu_ready;

  // Hold EX back when the popping load targets the same rd, so the load's
  // (older) write lands first and the EX write overwrites it a cycle later.
  assign ex_ready = !rst && !flush &&
                    !(pop && (head.rd == ex_rd_addr) && (ex_rd_addr != 5'd0));
  assign ex_acc   = ex_valid && ex_ready;

  // FIFO storage: written on push only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{rd: lsu_rd_addr, data: lsu_fmt(lsu_rdata, lsu_funct3, lsu_byte_off)};
  end

  // FIFO pointers and occupancy; flush empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // EX write port: one-cycle registered copy of the accepted result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ex_wen  <= 1'b0;
      wb_ex_addr <= '0;
      wb_ex_data <= '0;
    end else begin
      wb_ex_wen <= ex_acc && (ex_rd_addr != 5'd0);
      if (ex_acc) begin
        wb_ex_addr <= ex_rd_addr;
        wb_ex_data <= ex_rd_data;
      end
    end
  end

  // LSU write port: registered copy of the FIFO head popped this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_lsu_wen  <= 1'b0;
      wb_lsu_addr <= '0;
      wb_lsu_data <= '0;
    end else begin
      wb_lsu_wen <= pop && (head.rd != 5'd0);
      if (pop) begin
        wb_lsu_addr <= head.rd;
        wb_lsu_data <= head.data;
      end
    end
  end

  // Scoreboard next state: clears from this cycle's writes, then issue set wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_ex_wen)  busy_nxt[wb_ex_addr]  = 1'b0;
    if (wb_lsu_wen) busy_nxt[wb_lsu_addr] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register; flush wipes every pending mark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        busy <= '0;
    else if (flush) busy <= '0;
    else            busy <= busy_nxt;
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

endmodule
